// File: rtl/lfsr_rand_arbiter.sv
// rtl/lfsr_rand_arbiter.sv - LFSR-seeded round-robin arbiter with warm-up and grant stride.
// Optional grant counter port is enabled by defining LFSR_ARB_STATS_EN.
module lfsr_rand_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          WARMUP     = 32,
  parameter int          STRIDE     = 8,
  parameter logic [31:0] RESET_SEED = 32'hACE1_2468
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        seed,
  input  logic               seed_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rand_out,
  output logic               rand_valid,
`ifdef LFSR_ARB_STATS_EN
  output logic [31:0]        grant_count,
`endif
  output logic               busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_WARMUP   = 2'd0;
  localparam logic [1:0] ST_READY    = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;

  logic [31:0]        lfsr;
  logic [31:0]        lfsr_next;
  logic [1:0]         state;
  logic [31:0]        cnt;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_next;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  int                 idx;

  assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  // The requester holding the grant this cycle is masked so it cannot win twice in a row.
  assign elig      = req & ~gnt;
  assign busy      = (state == ST_WARMUP);
  assign gnt_next  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && elig[idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = win_idx + 1'b1;
    if (int'(win_idx) == NUM_REQ - 1) ptr_next = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr        <= RESET_SEED;
      state       <= ST_WARMUP;
      cnt         <= 32'(WARMUP);
      ptr         <= '0;
      gnt         <= '0;
      rand_valid  <= 1'b0;
      rand_out    <= '0;
`ifdef LFSR_ARB_STATS_EN
      grant_count <= '0;
`endif
    end else begin
      gnt        <= '0;
      rand_valid <= 1'b0;
      if (seed_load) begin
        // A zero seed would lock the LFSR at zero forever.
        lfsr  <= (seed == 32'h0) ? 32'h1 : seed;
        cnt   <= 32'(WARMUP);
        state <= ST_WARMUP;
`ifdef LFSR_ARB_STATS_EN
        grant_count <= '0;
`endif
      end else begin
        lfsr <= lfsr_next;
        case (state)
          ST_WARMUP, ST_COOLDOWN: begin
            cnt <= cnt - 32'd1;
            if (cnt == 32'd1) state <= ST_READY;
          end
          ST_READY: begin
            if (win_found) begin
              gnt        <= gnt_next;
              rand_out   <= lfsr;
              rand_valid <= 1'b1;
              ptr        <= ptr_next;
`ifdef LFSR_ARB_STATS_EN
              grant_count <= grant_count + 32'd1;
`endif
              if (STRIDE > 1) begin
                state <= ST_COOLDOWN;
                cnt   <= 32'(STRIDE - 1);
              end
            end
          end
          default: begin
            state <= ST_WARMUP;
            cnt   <= 32'(WARMUP);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb/tb_lfsr_rand_arbiter.sv - directed self-checking bench for lfsr_rand_arbiter.
module tb_lfsr_rand_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seed;
  logic        seed_load;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rand_out;
  logic        rand_valid;
  logic        busy;
  logic [3:0]  req8;
  logic [3:0]  gnt8;
  logic [31:0] rand_out8;
  logic        rand_valid8;
  logic        busy8;
`ifdef LFSR_ARB_STATS_EN
  logic [31:0] grant_count;
  logic [31:0] grant_count8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rand_arbiter #(.NUM_REQ(4), .WARMUP(2), .STRIDE(1)) u_dut (
    .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load), .req(req),
    .gnt(gnt), .rand_out(rand_out), .rand_valid(rand_valid),
`ifdef LFSR_ARB_STATS_EN
    .grant_count(grant_count),
`endif
    .busy(busy)
  );

  lfsr_rand_arbiter #(.NUM_REQ(4), .WARMUP(4), .STRIDE(8)) u_dut8 (
    .clk(clk), .reset(reset), .seed(32'h0), .seed_load(1'b0), .req(req8),
    .gnt(gnt8), .rand_out(rand_out8), .rand_valid(rand_valid8),
`ifdef LFSR_ARB_STATS_EN
    .grant_count(grant_count8),
`endif
    .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0]  rr_exp [5];
    logic [31:0] exp8;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b0; seed = '0; seed_load = 1'b0; req = '0; req8 = '0;

    // Asynchronous reset, checked before the first clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(rand_valid), 32'h0);
    check("rst_rand", rand_out, 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_lfsr", u_dut.lfsr, 32'hACE1_2468);
    repeat (2) @(negedge clk);

    // Reseed with 1, requester 2 held: grant on third edge with rand_out 6
    reset = 1'b0; seed_load = 1'b1; seed = 32'h1; req = 4'b0100;
    @(negedge clk); seed_load = 1'b0;
    check("ld_busy", 32'(busy), 32'h1);
    check("ld_lfsr", u_dut.lfsr, 32'h1);
    check("ld_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    check("w1_lfsr", u_dut.lfsr, 32'h3);
    check("w1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("w2_busy", 32'(busy), 32'h0);
    check("w2_gnt", 32'(gnt), 32'h0);
    check("w2_lfsr", u_dut.lfsr, 32'h6);
    @(negedge clk);
    check("g_gnt", 32'(gnt), 32'h4);
    check("g_rand", rand_out, 32'h6);
    check("g_valid", 32'(rand_valid), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_valid", 32'(rand_valid), 32'h0);
    check("hold_rand", rand_out, 32'h6);

    // Round robin with compliant drop/re-raise
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; req = 4'hF;
    @(negedge clk);
    check("rr_busy1", 32'(busy), 32'h1);
    @(negedge clk);
    check("rr_busy0", 32'(busy), 32'h0);
    check("rr_gnt0", 32'(gnt), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
      check("rr_valid", 32'(rand_valid), 32'h1);
      req = 4'hF & ~gnt;
    end
`ifdef LFSR_ARB_STATS_EN
    check("cnt_five", grant_count, 32'd5);
`endif

    // Reseed coinciding with an eligible request: reseed wins, request kept
    req = 4'b0100; seed_load = 1'b1; seed = 32'h5;
    @(negedge clk); seed_load = 1'b0;
    check("rs_gnt", 32'(gnt), 32'h0);
    check("rs_busy", 32'(busy), 32'h1);
`ifdef LFSR_ARB_STATS_EN
    check("cnt_clr", grant_count, 32'd0);
`endif
    @(negedge clk);
    check("rs_w1", 32'(busy), 32'h1);
    @(negedge clk);
    check("rs_w2", 32'(busy), 32'h0);
    @(negedge clk);
    check("rs_gnt2", 32'(gnt), 32'h4);
    check("rs_rand", rand_out, 32'h16);
    req = 4'b0000;

    // Zero seed is replaced by 1 and the LFSR keeps moving
    seed_load = 1'b1; seed = 32'h0;
    @(negedge clk); seed_load = 1'b0;
    check("z_lfsr", u_dut.lfsr, 32'h1);
    check("z_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("z_step", u_dut.lfsr, 32'h3);

    // Stride 8, two requesters: grants at cycles 5,13,21,29,37 alternating 0/1
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; req8 = 4'b0011;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      exp8 = 32'h0;
      if (c >= 5 && ((c - 5) % 8) == 0) exp8 = ((((c - 5) / 8) % 2) == 1) ? 32'h2 : 32'h1;
      check("st_gnt", 32'(gnt8), exp8);
      check("st_busy_gnt", 32'(busy8 & (|gnt8)), 32'h0);
      if (c < 37) req8 = 4'b0011 & ~gnt8;
    end

    // Reset during a grant / cooldown takes effect without a clock edge
    reset = 1'b1;
    #1;
    check("rc_gnt", 32'(gnt8), 32'h0);
    check("rc_rand", rand_out8, 32'h0);
    check("rc_valid", 32'(rand_valid8), 32'h0);
    check("rc_busy", 32'(busy8), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_arbiter.md
LFSR_RAND_ARBITER -- requirements
Module: lfsr_rand_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; SHALL be 2..8.
REQ-002 Parameter WARMUP, default 32, LFSR steps discarded after reset/reseed; SHALL be >=1.
REQ-003 Parameter STRIDE, default 8, minimum cycles between consecutive grants; SHALL be >=1.
REQ-004 Parameter RESET_SEED, default 32'hACE1_2468, LFSR value loaded by reset; SHALL be nonzero.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 seed  in  32  reseed value, sampled when seed_load=1.
REQ-008 seed_load  in  1  single-cycle reseed strobe.
REQ-009 req  in  NUM_REQ  per-requester request level.
REQ-010 gnt  out  NUM_REQ  registered one-hot grant, one cycle wide.
REQ-011 rand_out  out  32  registered random word, valid while rand_valid=1.
REQ-012 rand_valid  out  1  high exactly in cycles where gnt is nonzero.
REQ-013 busy  out  1  high while in WARMUP state.

Function
REQ-014 Internal 32-bit LFSR SHALL step as next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]} on every edge except a seed_load edge.
REQ-015 FSM states SHALL be WARMUP, READY and COOLDOWN.
REQ-016 seed_load=1 in any state: lfsr<=seed, or 32'h1 if seed==0 (lock-up guard); cnt<=WARMUP; state<=WARMUP; no grant on that edge.
REQ-017 WARMUP: cnt decrements each edge; on the edge where cnt==1, state<=READY; no grants are issued.
REQ-018 READY with eligible request: gnt<=one-hot winner, rand_out<=pre-step lfsr, rand_valid<=1; state<=COOLDOWN with cnt<=STRIDE-1, or stays READY if STRIDE==1.
REQ-019 COOLDOWN: no grants; cnt decrements; on the edge where cnt==1, state<=READY.
REQ-020 Eligible = req[i]=1 and gnt[i]=0 (the requester being granted in the current cycle is masked).
REQ-021 Arbitration SHALL be round-robin: search starts at pointer ptr and ascends modulo NUM_REQ; after a grant to i, ptr<=(i+1) mod NUM_REQ; ptr is unchanged when there is no grant.
REQ-022 gnt and rand_valid SHALL return to 0 on the edge following any grant unless a new grant issues; rand_out SHALL hold its last value.
REQ-023 A requester SHALL deassert req in the cycle its gnt is high; the block SHALL NOT buffer requests.
REQ-024 seed_load simultaneous with an eligible request: reseed wins; request stays pending.

Reset
REQ-025 reset=1 SHALL immediately force lfsr=RESET_SEED, state=WARMUP, cnt=WARMUP, ptr=0, gnt=0, rand_valid=0, rand_out=0, busy=1.
REQ-026 reset mid-cooldown or mid-grant SHALL discard the grant and restart warm-up.

Configuration
REQ-027 Macro LFSR_ARB_STATS_EN defined: add output grant_count[31:0], incremented per grant, wrapping at 2^32, cleared by reset and by seed_load.
REQ-028 Macro LFSR_ARB_STATS_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 WARMUP=2, STRIDE=1; seed_load with seed=32'h1; req=4'b0100 held -> third edge after the load: gnt=4'b0100, rand_out=32'h00000006, rand_valid=1.
REQ-030 seed_load with seed=32'h0 -> lfsr=32'h1 and busy=1 on the next cycle; no lock-up.
REQ-031 STRIDE=1; req=4'b1111 held with compliant drop/re-raise -> grant order 0,1,2,3,0.
REQ-032 STRIDE=8, two requesters active -> grant-to-grant spacing exactly 8 cycles; no grant while busy=1.
REQ-033 reset asserted in COOLDOWN -> gnt=0, rand_out=0, busy=1 with no clock edge required.
REQ-034 LFSR_ARB_STATS_EN defined, 5 grants then seed_load -> grant_count=5, then 0.
